// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the load/shift sequencing controller:
// FSM state encoding and the shift-length saturation rule.
package shift_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A zero or over-range request means a full-width shift.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Shift counter: synchronous clear on accept, increment on each shift strobe,
// and a terminal-count flag raised when the next shift will be the last one.
module shift_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // term is always at least 1, so term-1 never wraps in use.
    assign last_c = (cnt == (term - CNT_W'(1)));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the parallel-load / serial-shift datapath:
// one load strobe, then exactly len_eff shift strobes (stall-aware), then done.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             stall,
    input  logic             abort,
    output logic             ready,
    output logic             load,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] len_sat;
    logic             accept;
    logic             last_shift;

    assign len_sat = CNT_W'(sat_len(32'(len), WIDTH));

    // State register and length latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            len_eff <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                len_eff <= len_sat;
            end
        end
    end

    // Next-state and strobe decode; abort outranks stall and the final shift.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready      = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load       = 1'b1;
                busy       = 1'b1;
                state_next = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (!stall) begin
                    shift_en = 1'b1;
                    if (last_shift) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done       = !abort;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    shift_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (shift_en),
        .term   (len_eff),
        .cnt    (shift_cnt),
        .last_c (last_shift)
    );

endmodule
